// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the Enka LEGv8 datapath: latches each fetched
// instruction and steps the shared units through per-instruction phases.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        i_ready,
    input  logic        alu_zero,
    input  logic        flag_n,
    input  logic        flag_v,
    input  logic        d_ack,
    input  logic        mul_done,
    output logic        i_req,
    output logic [31:0] ir,
    output logic        reg2loc,
    output logic        alu_src,
    output logic        imm_sel,
    output logic [2:0]  alu_op,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        mem_write,
    output logic        flag_we,
    output logic        pc_we,
    output logic        br_taken,
    output logic        uncond_br,
    output logic        d_req,
    output logic        mul_start,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR, OP_LSL,
        OP_LSR, OP_MUL, OP_B, OP_BLT, OP_CBZ, OP_ILL
    } op_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;
    op_t         op;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        op = OP_ILL;
        if (ir_q[31:22] == 10'b1001000100)                          op = OP_ADDI;
        else if (ir_q[31:21] == 11'b10101011000)                    op = OP_ADDS;
        else if (ir_q[31:21] == 11'b11101011000)                    op = OP_SUBS;
        else if (ir_q[31:21] == 11'b11111000010)                    op = OP_LDUR;
        else if (ir_q[31:21] == 11'b11111000000)                    op = OP_STUR;
        else if (ir_q[31:21] == 11'b11010011011)                    op = OP_LSL;
        else if (ir_q[31:21] == 11'b11010011010)                    op = OP_LSR;
        else if (ir_q[31:21] == 11'b10011011000)                    op = OP_MUL;
        else if (ir_q[31:26] == 6'b000101)                          op = OP_B;
        else if (ir_q[31:24] == 8'b01010100 && ir_q[4:0] == 5'b01011) op = OP_BLT;
        else if (ir_q[31:24] == 8'b10110100)                        op = OP_CBZ;
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no latch is inferred.
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        i_req      = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        imm_sel    = 1'b0;
        alu_op     = ALU_PASS_B;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        flag_we    = 1'b0;
        pc_we      = 1'b0;
        br_taken   = 1'b0;
        uncond_br  = 1'b0;
        d_req      = 1'b0;
        mul_start  = 1'b0;

        if (!rst) begin
            // Datapath selects are a pure function of the instruction and held
            // steady from DECODE to retirement so register reads can settle.
            if (state_q != S_FETCH && state_q != S_TRAP) begin
                case (op)
                    OP_ADDI: begin alu_src = 1'b1; alu_op = ALU_ADD; end
                    OP_ADDS: alu_op = ALU_ADD;
                    OP_SUBS: alu_op = ALU_SUB;
                    OP_LSL, OP_LSR: mem_to_reg = 2'd3;
                    OP_MUL:  mem_to_reg = 2'd2;
                    OP_LDUR: begin
                        alu_src    = 1'b1;
                        imm_sel    = 1'b1;
                        alu_op     = ALU_ADD;
                        mem_to_reg = 2'd1;
                    end
                    OP_STUR: begin
                        alu_src = 1'b1;
                        imm_sel = 1'b1;
                        alu_op  = ALU_ADD;
                        reg2loc = 1'b1;
                    end
                    OP_CBZ:  reg2loc = 1'b1;
                    default: ;
                endcase
            end

            case (state_q)
                S_FETCH: begin
                    i_req = 1'b1;
                    if (i_ready) begin
                        ir_d    = inst;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_ILL) begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (op)
                        OP_ADDI, OP_LSL, OP_LSR: begin
                            reg_write = 1'b1;
                            pc_we     = 1'b1;
                        end
                        OP_ADDS, OP_SUBS: begin
                            reg_write = 1'b1;
                            flag_we   = 1'b1;
                            pc_we     = 1'b1;
                        end
                        OP_B: begin
                            uncond_br = 1'b1;
                            br_taken  = 1'b1;
                            pc_we     = 1'b1;
                        end
                        OP_BLT: begin
                            br_taken = flag_n ^ flag_v;
                            pc_we    = 1'b1;
                        end
                        OP_CBZ: begin
                            br_taken = alu_zero;
                            pc_we    = 1'b1;
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            state_d   = S_MUL_WAIT;
                        end
                        OP_LDUR, OP_STUR: state_d = S_MEM;
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MUL_WAIT: begin
                    if (mul_done) begin
                        reg_write = 1'b1;
                        pc_we     = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_MEM: begin
                    d_req     = 1'b1;
                    mem_write = (op == OP_STUR);
                    if (d_ack) begin
                        if (op == OP_STUR) begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = S_FETCH;
                end
                S_TRAP: ;
                default: state_d = S_FETCH;
            endcase
        end

        retired_d = retired_q + {31'd0, pc_we};
    end

    assign ir      = rst ? 32'd0 : ir_q;
    assign illegal = illegal_q & ~rst;
    assign retired = rst ? 32'd0 : retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is scripted phase by phase from
// its class and the handshake delays chosen for it, and every cycle is compared.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        i_ready, alu_zero, flag_n, flag_v, d_ack, mul_done;
    logic        i_req, reg2loc, alu_src, imm_sel;
    logic [31:0] ir, retired;
    logic [2:0]  alu_op;
    logic [1:0]  mem_to_reg;
    logic        reg_write, mem_write, flag_we, pc_we, br_taken, uncond_br;
    logic        d_req, mul_start, illegal;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .inst(inst), .i_ready(i_ready), .alu_zero(alu_zero),
        .flag_n(flag_n), .flag_v(flag_v), .d_ack(d_ack), .mul_done(mul_done),
        .i_req(i_req), .ir(ir), .reg2loc(reg2loc), .alu_src(alu_src), .imm_sel(imm_sel),
        .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_write(mem_write), .flag_we(flag_we), .pc_we(pc_we), .br_taken(br_taken),
        .uncond_br(uncond_br), .d_req(d_req), .mul_start(mul_start), .illegal(illegal),
        .retired(retired)
    );

    typedef enum int {
        K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_LSL, K_LSR, K_MUL, K_B, K_BLT, K_CBZ, K_ILL
    } kind_t;

    typedef struct packed {
        logic       i_req;
        logic       reg2loc;
        logic       alu_src;
        logic       imm_sel;
        logic [2:0] alu_op;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       flag_we;
        logic       pc_we;
        logic       br_taken;
        logic       uncond_br;
        logic       d_req;
        logic       mul_start;
        logic       illegal;
    } ctl_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_ir;
    logic [31:0] m_retired;
    bit          fix_flags = 1'b0;
    logic        fix_n = 1'b0;
    logic        fix_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o = {i_req, reg2loc, alu_src, imm_sel, alu_op, mem_to_reg, reg_write, mem_write,
             flag_we, pc_we, br_taken, uncond_br, d_req, mul_start, illegal};
        return o;
    endfunction

    function automatic logic [31:0] make_word(input kind_t k);
        logic [31:0] r;
        logic [31:0] bad [3];
        r = $urandom;
        bad[0] = 32'h0000_0000;
        bad[1] = 32'hFFFF_FFFF;
        bad[2] = 32'h5400_0040;
        case (k)
            K_ADDI:  return {10'b1001000100, r[21:0]};
            K_ADDS:  return {11'b10101011000, r[20:0]};
            K_SUBS:  return {11'b11101011000, r[20:0]};
            K_LDUR:  return {11'b11111000010, r[20:0]};
            K_STUR:  return {11'b11111000000, r[20:0]};
            K_LSL:   return {11'b11010011011, r[20:0]};
            K_LSR:   return {11'b11010011010, r[20:0]};
            K_MUL:   return {11'b10011011000, r[20:0]};
            K_B:     return {6'b000101, r[25:0]};
            K_BLT:   return {8'b01010100, r[18:0], 5'b01011};
            K_CBZ:   return {8'b10110100, r[23:0]};
            default: return bad[$urandom_range(0, 2)];
        endcase
    endfunction

    // Select outputs each instruction class holds from DECODE until it retires.
    function automatic ctl_t sel_of(input kind_t k);
        ctl_t e;
        e = '0;
        case (k)
            K_ADDI: begin e.alu_src = 1'b1; e.alu_op = 3'b010; end
            K_ADDS: e.alu_op = 3'b010;
            K_SUBS: e.alu_op = 3'b011;
            K_LSL, K_LSR: e.mem_to_reg = 2'd3;
            K_MUL:  e.mem_to_reg = 2'd2;
            K_LDUR: begin e.alu_src = 1'b1; e.imm_sel = 1'b1; e.alu_op = 3'b010; e.mem_to_reg = 2'd1; end
            K_STUR: begin e.alu_src = 1'b1; e.imm_sel = 1'b1; e.alu_op = 3'b010; e.reg2loc = 1'b1; end
            K_CBZ:  e.reg2loc = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic new_cycle();
        @(negedge clk);
        rst      = 1'b0;
        inst     = $urandom;
        i_ready  = 1'($urandom_range(0, 1));
        d_ack    = 1'($urandom_range(0, 1));
        mul_done = 1'($urandom_range(0, 1));
        alu_zero = 1'($urandom_range(0, 1));
        if (fix_flags) begin
            flag_n = fix_n;
            flag_v = fix_v;
        end else begin
            flag_n = 1'($urandom_range(0, 1));
            flag_v = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_cyc(input ctl_t e, input string tag);
        ctl_t o;
        #1;
        o = observed();
        check({tag, " ctl"}, {14'd0, o}, {14'd0, e});
        check({tag, " ir"}, ir, m_ir);
        check({tag, " retired"}, retired, m_retired);
    endtask

    task automatic do_reset();
        ctl_t o;
        @(negedge clk);
        rst      = 1'b1;
        i_ready  = 1'b1;
        d_ack    = 1'b1;
        mul_done = 1'b1;
        inst     = $urandom;
        #1;
        o = observed();
        check("rst ctl", {14'd0, o}, 32'd0);
        check("rst ir", ir, 32'd0);
        check("rst retired", retired, 32'd0);
        m_ir      = '0;
        m_retired = '0;
    endtask

    // f_wait: I$ stall cycles; x_wait: D$/multiplier cycles before the handshake;
    // abort: index of the wait cycle in which rst is asserted (-1 for none).
    task automatic run_instr(input kind_t k, input logic [31:0] w, input int f_wait,
                             input int x_wait, input int abort);
        ctl_t e;
        ctl_t s;
        s = sel_of(k);
        for (int i = 0; i <= f_wait; i++) begin
            new_cycle();
            i_ready = (i == f_wait);
            if (i == f_wait) inst = w;
            e = '0;
            e.i_req = 1'b1;
            check_cyc(e, "fetch");
        end
        m_ir = w;

        new_cycle();
        check_cyc(s, "decode");

        if (k == K_ILL) begin
            repeat (3) begin
                new_cycle();
                e = '0;
                e.illegal = 1'b1;
                check_cyc(e, "trap");
            end
            return;
        end

        new_cycle();
        e = s;
        case (k)
            K_ADDI, K_LSL, K_LSR: begin e.reg_write = 1'b1; e.pc_we = 1'b1; end
            K_ADDS, K_SUBS: begin e.reg_write = 1'b1; e.flag_we = 1'b1; e.pc_we = 1'b1; end
            K_B:   begin e.uncond_br = 1'b1; e.br_taken = 1'b1; e.pc_we = 1'b1; end
            K_BLT: begin e.br_taken = flag_n ^ flag_v; e.pc_we = 1'b1; end
            K_CBZ: begin e.br_taken = alu_zero; e.pc_we = 1'b1; end
            K_MUL: e.mul_start = 1'b1;
            default: ;
        endcase
        check_cyc(e, "exec");
        if (e.pc_we) m_retired++;

        if (k == K_MUL || k == K_LDUR || k == K_STUR) begin
            for (int i = 0; i <= x_wait; i++) begin
                if (i == abort) begin
                    do_reset();
                    return;
                end
                new_cycle();
                e = s;
                if (k == K_MUL) begin
                    mul_done = (i == x_wait);
                    if (mul_done) begin e.reg_write = 1'b1; e.pc_we = 1'b1; end
                    check_cyc(e, "mul_wait");
                end else begin
                    d_ack = (i == x_wait);
                    e.d_req = 1'b1;
                    e.mem_write = (k == K_STUR);
                    if (d_ack && k == K_STUR) e.pc_we = 1'b1;
                    check_cyc(e, "mem");
                end
                if (e.pc_we) m_retired++;
            end
            if (k == K_LDUR) begin
                new_cycle();
                e = s;
                e.reg_write = 1'b1;
                e.pc_we = 1'b1;
                check_cyc(e, "wb");
                m_retired++;
            end
        end
    endtask

    initial begin
        kind_t k;
        int    xw;
        int    ab;
        rst = 1'b1; inst = '0; i_ready = 1'b0; alu_zero = 1'b0;
        flag_n = 1'b0; flag_v = 1'b0; d_ack = 1'b0; mul_done = 1'b0;
        m_ir = '0; m_retired = '0;

        do_reset();
        do_reset();

        run_instr(K_ADDI, 32'h910017E1, 0, 0, -1);

        fix_flags = 1'b1; fix_n = 1'b1; fix_v = 1'b0;
        run_instr(K_SUBS, make_word(K_SUBS), 0, 0, -1);
        run_instr(K_BLT, 32'h5400004B, 0, 0, -1);
        fix_n = 1'b1; fix_v = 1'b1;
        run_instr(K_SUBS, make_word(K_SUBS), 1, 0, -1);
        run_instr(K_BLT, 32'h5400004B, 0, 0, -1);
        fix_flags = 1'b0;

        run_instr(K_LDUR, make_word(K_LDUR), 0, 3, -1);
        run_instr(K_MUL, make_word(K_MUL), 0, 4, -1);
        run_instr(K_STUR, make_word(K_STUR), 0, 0, -1);

        run_instr(K_STUR, make_word(K_STUR), 0, 3, 2);
        run_instr(K_ADDI, make_word(K_ADDI), 0, 0, -1);
        run_instr(K_MUL, make_word(K_MUL), 0, 3, 1);
        run_instr(K_B, make_word(K_B), 2, 0, -1);

        run_instr(K_ILL, 32'h0000_0000, 0, 0, -1);
        do_reset();
        run_instr(K_ILL, 32'h5400_0040, 1, 0, -1);
        do_reset();
        run_instr(K_CBZ, make_word(K_CBZ), 0, 0, -1);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 14) == 0) k = K_ILL;
            else k = kind_t'($urandom_range(0, 10));
            xw = $urandom_range(0, 4);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, xw) : -1;
            run_instr(k, make_word(k), $urandom_range(0, 3), xw, ab);
            if (k == K_ILL) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the Enka LEGv8 datapath. It latches each fetched instruction and steps the shared ALU, multiplier, shifter, register file and D$ through per-instruction phases. It handles variable-latency D$ and multiplier handshakes, and drives every datapath select and write enable. It replaces the single-cycle flat decode with an FSM so multi-cycle units can stall the core.

## Interface
- No parameters; opcodes are fixed by the ISA subset.
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  32  instruction word from I$
- i_ready  in  1  I$ word valid this cycle
- alu_zero  in  1  ALU result-zero, combinational (used by CBZ)
- flag_n, flag_v  in  1 each  registered N and V flags
- d_ack  in  1  D$ access complete
- mul_done  in  1  multiplier result valid
- i_req  out  1  fetch request
- ir  out  32  latched instruction register
- reg2loc  out  1  Ab source: 0 = Rm, 1 = Rd
- alu_src  out  1  ALU B input: 0 = Db, 1 = immediate
- imm_sel  out  1  0 = imm12 zero-extended, 1 = imm9 sign-extended
- alu_op  out  3  000 pass B, 010 add, 011 sub
- mem_to_reg  out  2  Dw source: 0 ALU, 1 D$, 2 multiplier low, 3 shifter
- reg_write, mem_write, flag_we, pc_we  out  1 each  write enables
- br_taken, uncond_br  out  1 each  next-PC select: branch target, and imm26 (vs imm19)
- d_req, mul_start  out  1 each  D$ request, multiplier one-cycle start pulse
- illegal  out  1  sticky undecodable-instruction indicator
- retired  out  32  count of completed instructions

## Operation
- Decode keys on ir: ADDI [31:22]=1001000100; ADDS [31:21]=10101011000; SUBS 11101011000; LDUR 11111000010; STUR 11111000000; LSL 11010011011; LSR 11010011010; MUL 10011011000; B [31:26]=000101; B.LT [31:24]=01010100 with [4:0]=01011; CBZ [31:24]=10110100. Anything else is illegal.
- States: FETCH, DECODE, EXEC, MUL_WAIT, MEM, WB, TRAP. Encoded in 3 bits.
- FETCH: i_req=1. When i_ready is high, capture inst into ir and go to DECODE. Otherwise stay.
- DECODE: if illegal, go to TRAP. Otherwise go to EXEC. Select outputs are valid from DECODE onward so the register file reads settle.
- EXEC, by instruction:
  - ADDI: alu_src=1, imm_sel=0, add, reg_write, pc_we, then FETCH.
  - ADDS/SUBS: add/sub, reg_write, flag_we, pc_we, then FETCH.
  - LSL/LSR: mem_to_reg=3, reg_write, pc_we, then FETCH.
  - B: uncond_br=1, br_taken=1, pc_we, then FETCH.
  - B.LT: br_taken = flag_n^flag_v, pc_we, then FETCH.
  - CBZ: reg2loc=1, pass B, br_taken=alu_zero, pc_we, then FETCH.
  - MUL: mul_start=1, then MUL_WAIT.
  - LDUR/STUR: alu_src=1, imm_sel=1, add, then MEM. STUR also sets reg2loc=1.
- MUL_WAIT: hold. On mul_done: mem_to_reg=2, reg_write, pc_we, then FETCH.
- MEM: d_req=1, with the address selects held from EXEC. STUR also drives mem_write=1. On d_ack: STUR asserts pc_we and goes to FETCH; LDUR goes to WB.
- WB: mem_to_reg=1, reg_write, pc_we, then FETCH.
- TRAP: illegal=1 and all enables/requests 0. Exit only via rst.
- retired increments by 1 in every cycle pc_we=1. It wraps at 2^32-1 to 0.

## Timing
- Outputs are combinational from registered state and ir. ir, state, illegal and retired are registered.
- During any cycle with rst=1, every output is forced to 0.
- After reset: state=FETCH, ir=0, illegal=0, retired=0, and all enables/requests are 0 except i_req=1 in the first post-reset cycle.
- Latency with zero-wait I$/D$ (i_ready and d_ack high on first request):
  - ALU/branch instructions: 3 cycles.
  - STUR: 4 cycles.
  - LDUR: 5 cycles.
  - MUL: 4 cycles plus mul_done latency (mul_done earliest the cycle after mul_start).
- d_req stays asserted until d_ack. d_ack, mul_done and i_ready are ignored outside MEM, MUL_WAIT and FETCH respectively.
- mul_start is high for exactly one cycle per MUL.
- pc_we is high for exactly one cycle per retired instruction. reg_write and pc_we coincide.
- rst asserted mid-MEM or mid-MUL_WAIT: the next cycle is FETCH, with no reg_write, mem_write or pc_we issued for the aborted instruction.

## Test plan
- Reset, then ADDI X1,X31,#5 (0x910017E1) with i_ready tied high. Required: DECODE then EXEC; in EXEC reg_write=1, alu_src=1, alu_op=010, pc_we=1; retired=1 after cycle 3.
- SUBS with flag_n=1, flag_v=0, then B.LT (0x5400004B). Required: flag_we=1 in SUBS EXEC; B.LT EXEC has br_taken=1, uncond_br=0. Repeat with flag_n=flag_v=1: br_taken=0.
- LDUR with d_ack delayed 3 cycles. Required: d_req high 4 consecutive cycles with mem_write=0; WB asserts mem_to_reg=1, reg_write=1; total 8 cycles.
- MUL with mul_done 5 cycles after mul_start. Required: one-cycle mul_start, reg_write with mem_to_reg=2 on the mul_done cycle; stray mul_done during FETCH has no effect.
- Instruction 0x00000000. Required: TRAP after DECODE, illegal=1, no further i_req; rst clears illegal and restarts FETCH.
- rst asserted while STUR in MEM with d_ack low. Required: mem_write never asserts alongside d_ack, retired unchanged, FETCH next cycle.
